// File: rtl/kernel_write_control_if.sv
// kernel_write_control_if
//   Groups the weight-stream handshake and the kernel-memory write bus.
//   Handshake: a word moves on a cycle where in_valid and in_ready are both
//   high; in_valid may rise or fall at will and in_data is only meaningful
//   while in_valid is high. in_ready is a pure function of the loader state
//   (high only while loading).
//   Ports:
//     in_data / in_valid      : weight stream from the source (master drives)
//     in_ready                : loader accepts a word this cycle
//     write_kernel_addr/data  : kernel memory write address / data
//     write_kernel_en         : one-hot bank write enable, bit n = bank n
//   Modports: master = stream source / memory side, slave = the loader.
interface kernel_write_control_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [8:0]        write_kernel_addr;
   logic [DATA_W-1:0] write_kernel_data;
   logic [3:0]        write_kernel_en;

   modport master (
      output in_data, in_valid,
      input  in_ready, write_kernel_addr, write_kernel_data, write_kernel_en
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, write_kernel_addr, write_kernel_data, write_kernel_en
   );
endinterface

// File: rtl/kernel_write_control.sv
// kernel_write_control
//   Loads kernel weights into the 4-bank kernel memory. Each accepted word
//   goes to the next bank in rotation 0..3; the 9-bit kernel address advances
//   after every bank-3 word. The write appears on the bus one cycle after
//   acceptance. A load cannot start while cnn_busy is high.
//   Ports:
//     clk, reset        : clock, asynchronous active-low reset
//     load_start        : 1-cycle request to begin a (re)load
//     load_abort        : 1-cycle cancel; beats start and any word that cycle
//     cnn_busy          : inference running, blocks load_start
//     bus (slave)       : weight stream in, kernel memory write bus out
//     load_busy         : state is LOAD
//     load_done         : full load completed, held until next start or abort
//     load_checksum     : mod-2^16 sum of accepted words (optional)
//     state_dbg         : current FSM state encoding
//   Optional feature macro: KERNEL_WRITE_CHECKSUM_EN adds load_checksum.
module kernel_write_control #(
   parameter int DATA_W       = 16,
   parameter int KERNEL_DEPTH = 324
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_start,
   input  logic                   load_abort,
   input  logic                   cnn_busy,
   kernel_write_control_if.slave  bus,
   output logic                   load_busy,
   output logic                   load_done,
`ifdef KERNEL_WRITE_CHECKSUM_EN
   output logic [15:0]            load_checksum,
`endif
   output logic [1:0]             state_dbg
);

   localparam logic [8:0] LAST_ADDR = 9'(KERNEL_DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        bank_q, bank_d;
   logic [8:0]        addr_q, addr_d;
   logic [3:0]        wen_q, wen_d;
   logic [8:0]        waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef KERNEL_WRITE_CHECKSUM_EN
   logic [15:0]       csum_q, csum_d;
`endif

   logic accept;
   logic start_ok;
   logic last_word;

   assign bus.in_ready = (state_q == ST_LOAD);
   // An abort in the same cycle discards the word on the bus.
   assign accept    = bus.in_valid & bus.in_ready & ~load_abort;
   assign start_ok  = load_start & ~cnn_busy & ~load_abort;
   assign last_word = (bank_q == 2'd3) && (addr_q == LAST_ADDR);

   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      addr_d  = addr_q;
      wen_d   = 4'b0000;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
`ifdef KERNEL_WRITE_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = ST_LOAD;
               bank_d  = 2'd0;
               addr_d  = 9'd0;
`ifdef KERNEL_WRITE_CHECKSUM_EN
               csum_d  = 16'd0;
`endif
            end
         end
         ST_LOAD: begin
            if (load_abort) begin
               state_d = ST_IDLE;
               bank_d  = 2'd0;
               addr_d  = 9'd0;
`ifdef KERNEL_WRITE_CHECKSUM_EN
               csum_d  = 16'd0;
`endif
            end else if (accept) begin
               wen_d   = 4'(4'b0001 << bank_q);
               waddr_d = addr_q;
               wdata_d = bus.in_data;
`ifdef KERNEL_WRITE_CHECKSUM_EN
               csum_d  = csum_q + 16'(bus.in_data);
`endif
               if (last_word) begin
                  // Counters stay parked on the final location.
                  state_d = ST_DONE;
               end else begin
                  bank_d = bank_q + 2'd1;
                  if (bank_q == 2'd3) begin
                     addr_d = addr_q + 9'd1;
                  end
               end
            end
         end
         ST_DONE: begin
            if (load_abort) begin
               state_d = ST_IDLE;
               bank_d  = 2'd0;
               addr_d  = 9'd0;
`ifdef KERNEL_WRITE_CHECKSUM_EN
               csum_d  = 16'd0;
`endif
            end else if (start_ok) begin
               state_d = ST_LOAD;
               bank_d  = 2'd0;
               addr_d  = 9'd0;
`ifdef KERNEL_WRITE_CHECKSUM_EN
               csum_d  = 16'd0;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         bank_q  <= 2'd0;
         addr_q  <= 9'd0;
         wen_q   <= 4'b0000;
         waddr_q <= 9'd0;
         wdata_q <= '0;
`ifdef KERNEL_WRITE_CHECKSUM_EN
         csum_q  <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
`ifdef KERNEL_WRITE_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // Status outputs are straight decodes of the state register, so
   // load_done rises and load_busy falls with the final write pulse.
   assign load_busy             = (state_q == ST_LOAD);
   assign load_done             = (state_q == ST_DONE);
   assign state_dbg             = state_q;
   assign bus.write_kernel_en   = wen_q;
   assign bus.write_kernel_addr = waddr_q;
   assign bus.write_kernel_data = wdata_q;
`ifdef KERNEL_WRITE_CHECKSUM_EN
   assign load_checksum         = csum_q;
`endif

endmodule
